paddle_ctrl: RTL

Player-input front end for the Pong datapath. It sits directly upstream of the ball block and feeds it the two bar top edges plus the start pulse and animate enable. Raw board buttons are synchronised and debounced, converted into bar motion on each animation strobe, and clamped to the display. The start and pause buttons are turned into a one-cycle start pulse and a toggled animate level.

---
 rtl/paddle_ctrl_pkg.sv | 16 +
 rtl/paddle_ctrl_if.sv | 11 +
 rtl/paddle_ctrl_btn_debounce.sv | 28 ++
 rtl/paddle_ctrl.sv | 52 +++++
 4 files changed

// File: rtl/paddle_ctrl_pkg.sv
// paddle_ctrl_pkg: shared pong geometry defaults and bar motion helper
package paddle_ctrl_pkg;
  localparam int PONG_BAR_LENGTH = 180;
  localparam int PONG_BAR_SPEED = 4;
  localparam int PONG_D_HEIGHT = 470;
  localparam int POS_W = 12;
  typedef logic [POS_W-1:0] pos_t;
  typedef struct packed {
    logic dn;
    logic up;
  } bar_btn_t;
  function automatic pos_t bar_next(input pos_t top, input bar_btn_t b, input pos_t speed, input pos_t limit);
    return (b.up && !b.dn) ? ((top < speed) ? '0 : top - speed) :
           (b.dn && !b.up) ? ((top + speed > limit) ? limit : top + speed) : top;
  endfunction
endpackage

// File: rtl/paddle_ctrl_if.sv
// paddle_ctrl_if: bar positions, start pulse and animate level towards the ball block
interface paddle_ctrl_if;
  import paddle_ctrl_pkg::*;
  logic in_ani_stb;
  pos_t out_leftbar_top;
  pos_t out_rightbar_top;
  logic out_start;
  logic out_animate;
  modport master(input in_ani_stb, output out_leftbar_top, out_rightbar_top, out_start, out_animate);
  modport slave(output in_ani_stb, input out_leftbar_top, out_rightbar_top, out_start, out_animate);
endinterface

// File: rtl/paddle_ctrl_btn_debounce.sv
// btn_debounce: polarity fix, 2-flop synchroniser and consecutive-sample debounce
module btn_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
)(
  input  logic in_clock,
  input  logic in_reset_n,
  input  logic in_raw,
  output logic out_stable
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic diff, done;
  assign diff = sync[1] != out_stable;
  assign done = diff && cnt == LAST;
  always_ff @(posedge in_clock or negedge in_reset_n)
    if (!in_reset_n) begin
      sync <= '0;
      cnt <= '0;
      out_stable <= 1'b0;
    end else begin
      sync <= {sync[0], in_raw ^ BTN_ACTIVE_LOW};
      cnt <= (!diff || done) ? '0 : cnt + CW'(1);
      out_stable <= done ? sync[1] : out_stable;
    end
endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: debounced player buttons to bar positions, start pulse and pause toggle
module paddle_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int BAR_LENGTH = PONG_BAR_LENGTH,
  parameter int BAR_SPEED = PONG_BAR_SPEED,
  parameter int D_HEIGHT = PONG_D_HEIGHT,
  parameter int INIT_TOP = (D_HEIGHT - BAR_LENGTH) / 2,
  parameter int DEB_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
)(
  input  logic in_clock,
  input  logic in_reset_n,
  input  logic in_p1_up,
  input  logic in_p1_down,
  input  logic in_p2_up,
  input  logic in_p2_down,
  input  logic in_btn_start,
  input  logic in_btn_pause,
  paddle_ctrl_if.master bus
);
  localparam pos_t LIMIT = POS_W'(D_HEIGHT - BAR_LENGTH);
  localparam pos_t SPEED = POS_W'(BAR_SPEED);
  localparam pos_t INIT = POS_W'(INIT_TOP);
  logic [5:0] raw, deb, deb_q, rise;
  logic move;
  assign raw = {in_btn_pause, in_btn_start, in_p2_down, in_p2_up, in_p1_down, in_p1_up};
  assign rise = deb & ~deb_q;
  assign move = bus.in_ani_stb && bus.out_animate;
  for (genvar i = 0; i < 6; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_deb (
      .in_clock(in_clock),
      .in_reset_n(in_reset_n),
      .in_raw(raw[i]),
      .out_stable(deb[i])
    );
  end
  always_ff @(posedge in_clock or negedge in_reset_n)
    if (!in_reset_n) begin
      deb_q <= '0;
      bus.out_start <= 1'b0;
      bus.out_animate <= 1'b1;
      bus.out_leftbar_top <= INIT;
      bus.out_rightbar_top <= INIT;
    end else begin
      deb_q <= deb;
      bus.out_start <= rise[4];
      bus.out_animate <= bus.out_animate ^ rise[5];
      bus.out_leftbar_top <= move ? bar_next(bus.out_leftbar_top, deb[1:0], SPEED, LIMIT) : bus.out_leftbar_top;
      bus.out_rightbar_top <= move ? bar_next(bus.out_rightbar_top, deb[3:2], SPEED, LIMIT) : bus.out_rightbar_top;
    end
endmodule
